// File: rtl/adc_sample_sequencer_if.sv
// ---------------------------------------------------------------------------
// adc_sample_sequencer_if
//   Bundles the control inputs, the ADC pin-level signals and the sample
//   output of adc_sample_sequencer.
//   master : the sequencer (drives ADC strobes and the sample outputs)
//   slave  : the environment (drives enable/period and the ADC EOC/data pins)
//   Signals:
//     enable       run periodic sampling (level)
//     period[15:0] sample period in clocks, CONVST fall to CONVST fall
//     EOC_18       ADC end-of-conversion, active low, asynchronous
//     DB_18        ADC parallel data bus
//     CONVST_18    ADC convert start, active low
//     RD_18        ADC read strobe, active low
//     PD_18        ADC power control, low = powered down
//     sample_data  last captured sample
//     sample_valid one-cycle strobe for a new sample
//     busy         sequencer active (not idle / powered down)
//     tmo_err      EOC timeout strobe, only with ADC_SEQ_TIMEOUT_EN defined
// ---------------------------------------------------------------------------
interface adc_sample_sequencer_if #(
  parameter int DATA_W = 12
);
  logic              enable;
  logic [15:0]       period;
  logic              EOC_18;
  logic [DATA_W-1:0] DB_18;
  logic              CONVST_18;
  logic              RD_18;
  logic              PD_18;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              busy;
`ifdef ADC_SEQ_TIMEOUT_EN
  logic              tmo_err;

  modport master (
    input  enable, period, EOC_18, DB_18,
    output CONVST_18, RD_18, PD_18, sample_data, sample_valid, busy, tmo_err
  );
  modport slave (
    output enable, period, EOC_18, DB_18,
    input  CONVST_18, RD_18, PD_18, sample_data, sample_valid, busy, tmo_err
  );
`else
  modport master (
    input  enable, period, EOC_18, DB_18,
    output CONVST_18, RD_18, PD_18, sample_data, sample_valid, busy
  );
  modport slave (
    output enable, period, EOC_18, DB_18,
    input  CONVST_18, RD_18, PD_18, sample_data, sample_valid, busy
  );
`endif
endinterface

// File: rtl/adc_sample_sequencer.sv
// ---------------------------------------------------------------------------
// adc_sample_sequencer
//   Periodic conversion sequencer for a parallel-bus ADC: powers the ADC up,
//   issues CONVST pulses every `period` clocks, waits for end-of-conversion,
//   reads the data bus with an RD pulse and presents the sample.
//   Ports:
//     clk_100M  single 100 MHz clock
//     Reset     asynchronous active-low reset
//     bus       adc_sample_sequencer_if.master (control, ADC pins, sample out)
//   Optional feature: define ADC_SEQ_TIMEOUT_EN to abort an EOC wait after
//   TMO_CYC clocks (goes to GAP without capture and pulses bus.tmo_err).
//   WAKE_CYC must be >= 2; CONV_LOW, RD_LOW, TMO_CYC must be >= 1.
// ---------------------------------------------------------------------------
module adc_sample_sequencer #(
  parameter int DATA_W   = 12,
  parameter int CONV_LOW = 4,
  parameter int RD_LOW   = 6,
  parameter int WAKE_CYC = 16,
  parameter int TMO_CYC  = 1000
) (
  input  logic                  clk_100M,
  input  logic                  Reset,
  adc_sample_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_PWRDN, S_WAKE, S_IDLE, S_CONV, S_WAIT_EOC, S_READ, S_GAP
  } state_t;

  localparam logic [15:0] CONV_LAST = 16'(CONV_LOW - 1);
  localparam logic [15:0] RD_LAST   = 16'(RD_LOW - 1);
  // WAKE plus the single IDLE cycle span WAKE_CYC clocks from PD rise to
  // the first CONVST fall.
  localparam logic [15:0] WAKE_LAST = 16'(WAKE_CYC - 2);
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST  = 16'(TMO_CYC - 1);
`else
  // TMO_CYC only matters when the timeout is built in.
  localparam int tmo_cyc_unused = TMO_CYC;
`endif

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic [15:0]       r_pcnt;
  logic              r_eoc_s1, r_eoc_s2, r_eoc_s3;
  logic              w_eoc_evt;
  logic              w_period_hit;
  logic              r_convst, r_rd, r_pd, r_valid, r_busy;
  logic [DATA_W-1:0] r_sample;
`ifdef ADC_SEQ_TIMEOUT_EN
  logic              r_tmo;
`endif

  // Falling edge of the synchronized EOC. Flops reset to 0, so no event can
  // be produced by reset release while EOC idles high.
  assign w_eoc_evt = r_eoc_s3 & ~r_eoc_s2;

  // pcnt >= period-1, evaluated as pcnt+1 >= period so period=0 always hits.
  assign w_period_hit = ({1'b0, r_pcnt} + 17'd1) >= {1'b0, bus.period};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_PWRDN: if (bus.enable) w_state_nxt = S_WAKE;
      S_WAKE: begin
        if (!bus.enable)             w_state_nxt = S_PWRDN;
        else if (r_cnt == WAKE_LAST) w_state_nxt = S_IDLE;
        else                         w_cnt_nxt   = r_cnt + 16'd1;
      end
      S_IDLE: w_state_nxt = bus.enable ? S_CONV : S_PWRDN;
      S_CONV: begin
        if (r_cnt == CONV_LAST) w_state_nxt = S_WAIT_EOC;
        else                    w_cnt_nxt   = r_cnt + 16'd1;
      end
      S_WAIT_EOC: begin
        if (w_eoc_evt)              w_state_nxt = S_READ;
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (r_cnt == TMO_LAST) w_state_nxt = S_GAP;
        else                        w_cnt_nxt   = r_cnt + 16'd1;
`endif
      end
      S_READ: begin
        if (r_cnt == RD_LAST) w_state_nxt = S_GAP;
        else                  w_cnt_nxt   = r_cnt + 16'd1;
      end
      // enable is only looked at once the period has elapsed, so an
      // in-flight sample always completes before dropping to IDLE.
      S_GAP: if (w_period_hit) w_state_nxt = bus.enable ? S_CONV : S_IDLE;
      default: w_state_nxt = S_PWRDN;
    endcase
  end

  // Strobes are registered from the next state so they align with the state
  // they belong to and cannot glitch.
  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_PWRDN;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_eoc_s1 <= 1'b0;
      r_eoc_s2 <= 1'b0;
      r_eoc_s3 <= 1'b0;
      r_convst <= 1'b1;
      r_rd     <= 1'b1;
      r_pd     <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_sample <= '0;
`ifdef ADC_SEQ_TIMEOUT_EN
      r_tmo    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_eoc_s1 <= bus.EOC_18;
      r_eoc_s2 <= r_eoc_s1;
      r_eoc_s3 <= r_eoc_s2;
      // Zero on the CONVST-fall cycle, so pcnt equals clocks since the fall.
      if (w_state_nxt == S_CONV && r_state != S_CONV) r_pcnt <= '0;
      else if (r_pcnt != 16'hFFFF)                     r_pcnt <= r_pcnt + 16'd1;
      r_convst <= (w_state_nxt != S_CONV);
      r_rd     <= (w_state_nxt != S_READ);
      r_pd     <= (w_state_nxt != S_PWRDN);
      r_busy   <= !(w_state_nxt == S_IDLE || w_state_nxt == S_PWRDN);
      r_valid  <= (r_state == S_READ) && (w_state_nxt == S_GAP);
      if (r_state == S_READ && r_cnt == RD_LAST) r_sample <= bus.DB_18;
`ifdef ADC_SEQ_TIMEOUT_EN
      r_tmo    <= (r_state == S_WAIT_EOC) && (w_state_nxt == S_GAP);
`endif
    end
  end

  assign bus.CONVST_18    = r_convst;
  assign bus.RD_18        = r_rd;
  assign bus.PD_18        = r_pd;
  assign bus.sample_data  = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.busy         = r_busy;
`ifdef ADC_SEQ_TIMEOUT_EN
  assign bus.tmo_err      = r_tmo;
`endif

endmodule

// File: tb/tb_adc_sample_sequencer.sv
module tb_adc_sample_sequencer;
  localparam int DW   = 12;
  localparam int WAKE = 16;

  logic clk_100M = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  adc_sample_sequencer_if #(.DATA_W(DW)) bus ();

  adc_sample_sequencer #(
    .DATA_W(DW), .CONV_LOW(4), .RD_LOW(6), .WAKE_CYC(WAKE), .TMO_CYC(1000)
  ) dut (
    .clk_100M(clk_100M),
    .Reset   (Reset),
    .bus     (bus)
  );

  initial forever #5 clk_100M = ~clk_100M;
  always @(posedge clk_100M) cyc <= cyc + 1;

  // Observation queues (written by the monitor only).
  int q_cf[$], q_cl[$], q_rf[$], q_rl[$], q_vc[$], q_vd[$], q_pr[$], q_pf[$], q_ovl[$];
`ifdef ADC_SEQ_TIMEOUT_EN
  int q_tmo[$];
`endif
  // ADC stimulus record per conversion (written by the ADC model only).
  int q_d[$], q_db[$];

  // Control of the ADC model and queue clearing (written by main only).
  int          clr_req = 0;
  int          glitch_req = 0;
  int          adc_dly = 10;
  logic        adc_rand_db = 1'b0;
  logic        adc_mute = 1'b0;
  logic [DW-1:0] adc_db = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor: records edges and strobes at negedge
  initial begin : monitor
    logic cv_p, rd_p, pd_p;
    int   cl_run, rl_run, clr_ack;
    cv_p = 1'b1; rd_p = 1'b1; pd_p = 1'b0; cl_run = 0; rl_run = 0; clr_ack = 0;
    forever begin
      @(negedge clk_100M);
      if (clr_req != clr_ack) begin
        clr_ack = clr_req;
        q_cf.delete(); q_cl.delete(); q_rf.delete(); q_rl.delete();
        q_vc.delete(); q_vd.delete(); q_pr.delete(); q_pf.delete(); q_ovl.delete();
`ifdef ADC_SEQ_TIMEOUT_EN
        q_tmo.delete();
`endif
      end
      if (!bus.CONVST_18) begin
        if (cv_p) q_cf.push_back(cyc);
        cl_run++;
      end else if (!cv_p) begin
        q_cl.push_back(cl_run); cl_run = 0;
      end
      if (!bus.RD_18) begin
        if (rd_p) q_rf.push_back(cyc);
        rl_run++;
      end else if (!rd_p) begin
        q_rl.push_back(rl_run); rl_run = 0;
      end
      if (bus.PD_18 && !pd_p) q_pr.push_back(cyc);
      if (!bus.PD_18 && pd_p) q_pf.push_back(cyc);
      if (bus.sample_valid) begin
        q_vc.push_back(cyc); q_vd.push_back(int'(bus.sample_data));
      end
      if (!bus.CONVST_18 && !bus.RD_18) q_ovl.push_back(cyc);
`ifdef ADC_SEQ_TIMEOUT_EN
      if (bus.tmo_err) q_tmo.push_back(cyc);
`endif
      cv_p = bus.CONVST_18; rd_p = bus.RD_18; pd_p = bus.PD_18;
    end
  end

  // ---------------- ADC model: EOC falls adc_dly clocks after CONVST falls,
  // returns high when RD is seen low; optional 3-clock EOC glitch on request.
  initial begin : adc_model
    logic          cv_p;
    int            d_left, gl_left, adc_ack, glitch_done;
    logic [DW-1:0] nxt_db;
    logic [31:0]   r32;
    cv_p = 1'b1; d_left = -1; gl_left = 0; adc_ack = 0; glitch_done = 0; nxt_db = '0;
    bus.EOC_18 = 1'b1; bus.DB_18 = '0;
    forever begin
      @(posedge clk_100M); #1;
      if (clr_req != adc_ack) begin
        adc_ack = clr_req; q_d.delete(); q_db.delete();
      end
      if (!Reset) begin
        bus.EOC_18 = 1'b1; d_left = -1; gl_left = 0; cv_p = 1'b1;
      end else begin
        if (gl_left > 0) begin
          gl_left--;
          if (gl_left == 0) bus.EOC_18 = 1'b1;
        end else if (glitch_req != glitch_done) begin
          glitch_done = glitch_req; gl_left = 3; bus.EOC_18 = 1'b0;
        end
        if (cv_p && !bus.CONVST_18) begin
          d_left = (adc_dly > 0) ? adc_dly : int'($urandom_range(3, 40));
          r32 = $urandom;
          nxt_db = adc_rand_db ? r32[DW-1:0] : adc_db;
          q_d.push_back(d_left); q_db.push_back(int'(nxt_db));
        end
        cv_p = bus.CONVST_18;
        if (d_left == 0) begin
          if (!adc_mute) begin bus.EOC_18 = 1'b0; bus.DB_18 = nxt_db; end
          d_left = -1;
        end else if (d_left > 0) begin
          d_left--;
        end
        if (!bus.RD_18 && gl_left == 0) bus.EOC_18 = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_100M); #1;
    Reset = 1'b0; bus.enable = 1'b0;
    repeat (2) @(posedge clk_100M);
    clr_req++;
    repeat (2) @(posedge clk_100M);
    #1 Reset = 1'b1;
  endtask

  task automatic wait_valid(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (q_vc.size() < n && t < budget) begin
      @(negedge clk_100M); #1; t++;
    end
    if (q_vc.size() < n) check({name, " valid timeout"}, q_vc.size(), n);
  endtask

  task automatic wait_rd_low(input int budget, input string name);
    int t;
    t = 0;
    while (bus.RD_18 && t < budget) begin
      @(negedge clk_100M); t++;
    end
    if (bus.RD_18) check({name, " rd timeout"}, 1, 0);
  endtask

  typedef struct {
    int          period;
    int          dly;
    logic [11:0] db;
    int          exp_int;   // CONVST fall to next CONVST fall
    int          exp_rdd;   // CONVST fall to RD fall
  } vec_t;

  vec_t vt[6];

  initial begin : main
    int en_cyc, p, c, rf, nc;
    vt[0] = '{200, 50, 12'hA5C, 200, 53};
    vt[1] = '{0,   10, 12'h3C1, 20,  13};
    vt[2] = '{30,  10, 12'hFFF, 30,  13};
    vt[3] = '{15,  5,  12'h000, 15,  8};
    vt[4] = '{1,   5,  12'h5A5, 15,  8};
    vt[5] = '{100, 3,  12'h123, 100, 6};

    Reset = 1'b0; bus.enable = 1'b0; bus.period = 16'd0;

    // ---- reset state, then PWRDN hold with enable low
    repeat (3) @(posedge clk_100M); #1;
    check("rst convst", bus.CONVST_18, 1);
    check("rst rd", bus.RD_18, 1);
    check("rst pd", bus.PD_18, 0);
    check("rst valid", bus.sample_valid, 0);
    check("rst busy", bus.busy, 0);
    check("rst data", bus.sample_data, 0);
    Reset = 1'b1;
    repeat (10) @(posedge clk_100M); #1;
    check("pwrdn hold pd", bus.PD_18, 0);
    check("pwrdn hold busy", bus.busy, 0);

    // ---- table-driven vectors
    adc_rand_db = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.period = 16'(vt[i].period);
      adc_dly = vt[i].dly;
      adc_db = vt[i].db;
      @(posedge clk_100M); #1;
      en_cyc = cyc; bus.enable = 1'b1;
      wait_valid(2, 700, $sformatf("v%0d", i));
      check($sformatf("v%0d pd rise", i), q_pr[0] - en_cyc, 1);
      check($sformatf("v%0d wake", i), q_cf[0] - q_pr[0], WAKE);
      check($sformatf("v%0d convst len", i), q_cl[0], 4);
      check($sformatf("v%0d rd delay", i), q_rf[0] - q_cf[0], vt[i].exp_rdd);
      check($sformatf("v%0d rd len", i), q_rl[0], 6);
      check($sformatf("v%0d valid lat", i), q_vc[0] - q_rf[0], 6);
      check($sformatf("v%0d data0", i), q_vd[0], vt[i].db);
      check($sformatf("v%0d data1", i), q_vd[1], vt[i].db);
      check($sformatf("v%0d interval", i), q_cf[1] - q_cf[0], vt[i].exp_int);
      check($sformatf("v%0d overlap", i), q_ovl.size(), 0);
      check($sformatf("v%0d busy", i), bus.busy, 1);
    end

    // ---- randomized runs against a timing model
    adc_dly = 0; adc_rand_db = 1'b1;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      if (r == 0)      p = 0;
      else if (r == 1) p = int'($urandom_range(5, 40));
      else             p = int'($urandom_range(100, 250));
      bus.period = 16'(p);
      @(posedge clk_100M); #1; bus.enable = 1'b1;
      wait_valid(6, 3000, $sformatf("rand%0d", r));
      c = q_pr[0] + WAKE;
      for (int k = 0; k < 6; k++) begin
        rf = c + q_d[k] + 3;
        check($sformatf("r%0d.%0d convst fall", r, k), q_cf[k], c);
        check($sformatf("r%0d.%0d convst len", r, k), q_cl[k], 4);
        check($sformatf("r%0d.%0d rd fall", r, k), q_rf[k], rf);
        check($sformatf("r%0d.%0d rd len", r, k), q_rl[k], 6);
        check($sformatf("r%0d.%0d valid", r, k), q_vc[k], rf + 6);
        check($sformatf("r%0d.%0d data", r, k), q_vd[k], q_db[k]);
        nc = c + p;
        c = (nc > rf + 7) ? nc : rf + 7;
      end
      check($sformatf("r%0d overlap", r), q_ovl.size(), 0);
    end

    // ---- enable dropped while RD is low
    adc_dly = 10; adc_rand_db = 1'b0; adc_db = 12'h3A7;
    do_reset();
    bus.period = 16'd0;
    @(posedge clk_100M); #1; bus.enable = 1'b1;
    wait_rd_low(200, "endrop");
    @(posedge clk_100M); @(posedge clk_100M); #1; bus.enable = 1'b0;
    for (int t = 0; t < 200 && q_pf.size() == 0; t++) begin
      @(negedge clk_100M); #1;
    end
    repeat (5) @(negedge clk_100M); #1;
    check("endrop rd len", q_rl[0], 6);
    check("endrop valids", q_vc.size(), 1);
    check("endrop data", q_vd[0], 12'h3A7);
    check("endrop pd fall", q_pf[0] - q_vc[0], 2);
    check("endrop no new conv", q_cf.size(), 1);
    check("endrop busy", bus.busy, 0);

    // ---- asynchronous reset in the middle of READ
    do_reset();
    bus.period = 16'd200;
    @(posedge clk_100M); #1; bus.enable = 1'b1;
    wait_rd_low(200, "rstrd");
    @(posedge clk_100M); @(negedge clk_100M); #2;
    Reset = 1'b0; bus.enable = 1'b0;
    #1;
    check("rstrd rd", bus.RD_18, 1);
    check("rstrd convst", bus.CONVST_18, 1);
    check("rstrd pd", bus.PD_18, 0);
    check("rstrd data", bus.sample_data, 0);
    repeat (3) @(posedge clk_100M); #1 Reset = 1'b1;
    repeat (30) @(negedge clk_100M); #1;
    check("rstrd no valid", q_vc.size(), 0);
    check("rstrd no new rd", q_rf.size(), 1);
    check("rstrd stays down", bus.PD_18, 0);

    // ---- EOC glitch during GAP
    adc_db = 12'h6B2;
    do_reset();
    bus.period = 16'd200;
    @(posedge clk_100M); #1; bus.enable = 1'b1;
    wait_valid(1, 300, "glitch");
    glitch_req++;
    repeat (12) @(negedge clk_100M); #1;
    check("glitch no rd", q_rf.size(), 1);
    wait_valid(2, 400, "glitch2");
    check("glitch rd count", q_rf.size(), 2);
    check("glitch interval", q_cf[1] - q_cf[0], 200);
    check("glitch rd delay", q_rf[1] - q_cf[1], 13);
    check("glitch data", q_vd[1], 12'h6B2);

`ifdef ADC_SEQ_TIMEOUT_EN
    // ---- EOC never arrives
    adc_mute = 1'b1;
    do_reset();
    bus.period = 16'd1100;
    @(posedge clk_100M); #1; bus.enable = 1'b1;
    for (int t = 0; t < 1500 && q_cf.size() < 2; t++) begin
      @(negedge clk_100M); #1;
    end
    check("tmo count", q_tmo.size(), 1);
    check("tmo time", q_tmo[0] - q_cf[0], 1004);
    check("tmo no valid", q_vc.size(), 0);
    check("tmo no rd", q_rf.size(), 0);
    check("tmo next conv", q_cf[1] - q_cf[0], 1100);
    adc_mute = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_sequencer.md
ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 12, ADC data bus width; CONV_LOW, 4, CONVST_18 low pulse length in clocks; RD_LOW, 6, RD_18 low pulse length in clocks; WAKE_CYC, 16, clocks from PD_18 rising to first conversion; TMO_CYC, 1000, EOC wait limit in clocks.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk_100M, in, 1, single 100 MHz clock; Reset, in, 1, asynchronous active-low reset.
REQ-003 enable, in, 1, level; high = run periodic sampling.
REQ-004 period, in, 16, sample period in clocks, CONVST-fall to CONVST-fall.
REQ-005 EOC_18, in, 1, ADC end-of-conversion, active low, asynchronous to clk_100M.
REQ-006 DB_18, in, DATA_W, ADC parallel data bus.
REQ-007 CONVST_18, RD_18, PD_18, out, 1 each, ADC convert-start (active low), read strobe (active low), power control (low = powered down); all registered.
REQ-008 sample_data, out, DATA_W, last captured sample; sample_valid, out, 1, one-cycle strobe; busy, out, 1, high in any state except IDLE/PWRDN.

Function
REQ-009 EOC_18 SHALL pass a 2-flop synchronizer; an EOC event SHALL be a synchronized 1->0 transition.
REQ-010 FSM states SHALL be PWRDN, WAKE, IDLE, CONV, WAIT_EOC, READ, GAP.
REQ-011 PWRDN: PD_18=0; enable=1 -> WAKE with PD_18=1 on the next clock.
REQ-012 WAKE: count WAKE_CYC clocks, then IDLE; enable falling during WAKE -> PWRDN.
REQ-013 IDLE: enable=1 -> CONV; enable=0 -> PWRDN, PD_18=0 the next clock.
REQ-014 CONV: CONVST_18 low exactly CONV_LOW clocks; period counter SHALL clear on the cycle CONVST_18 falls; then WAIT_EOC.
REQ-015 WAIT_EOC: on EOC event -> READ; EOC events in other states SHALL be ignored.
REQ-016 READ: RD_18 low exactly RD_LOW clocks; DB_18 SHALL be captured into sample_data on the last RD-low cycle; sample_valid SHALL pulse one clock, the cycle after RD_18 returns high; then GAP.
REQ-017 GAP: when period counter >= period-1 -> CONV if enable=1, else IDLE; period=0 or period shorter than one conversion cycle SHALL give back-to-back conversions with no GAP clocks.
REQ-018 Period counter SHALL be 16 bits and SHALL saturate at 16'hFFFF, not wrap.
REQ-019 enable falling mid-conversion SHALL NOT truncate CONVST or RD pulses; the current sample SHALL complete, then IDLE.
REQ-020 period changes SHALL take effect at the next GAP comparison; no latching.
REQ-021 CONVST_18 and RD_18 SHALL never be low in the same cycle.

Reset
REQ-022 Reset low SHALL asynchronously force state PWRDN, CONVST_18=1, RD_18=1, PD_18=0, sample_data=0, sample_valid=0, busy=0, all counters and synchronizer flops 0 (synchronizer output treated as EOC high).
REQ-023 Reset release mid-pulse SHALL restart from PWRDN; no partial pulse SHALL resume.

Configuration
REQ-024 Macro ADC_SEQ_TIMEOUT_EN defined: WAIT_EOC exceeding TMO_CYC clocks SHALL go to GAP, skip capture, and pulse an extra output tmo_err (out, 1) for one clock.
REQ-025 Macro undefined: tmo_err port and timeout counter SHALL not exist; WAIT_EOC SHALL wait indefinitely.

Verification
REQ-026 Reset low mid-READ -> CONVST_18=1, RD_18=1, PD_18=0 immediately, no sample_valid.
REQ-027 enable=1, period=200, EOC falls 50 clocks after CONVST fall, DB_18=12'hA5C -> PD_18 high, after 16 clocks CONVST low 4 clocks, RD low 6 clocks, sample_valid with 12'hA5C, CONVST falls every 200 clocks.
REQ-028 period=0 -> next CONVST fall the clock after GAP entry; no RD/CONVST overlap.
REQ-029 enable dropped during RD low -> RD pulse completes 6 clocks, one sample_valid, then IDLE, then PD_18=0.
REQ-030 ADC_SEQ_TIMEOUT_EN defined, EOC held high -> tmo_err pulse 1000 clocks after WAIT_EOC entry, no sample_valid, next CONVST per period.
REQ-031 EOC glitch during GAP -> ignored, no RD pulse.
